// File: rtl/usart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, parity modes
// and the expected-parity helper.
package usart_pkg;

  // Receiver states, kept as plain constants so older code can use them directly
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    PAR   = ST_PAR,
    STOP  = ST_STOP
  } usart_state_e;

  // PARITY parameter encodings
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Parity bit a well-formed frame should carry, given the XOR of its data bits
  function automatic logic expected_parity(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/usart_sync_edge.sv
// Two-flop synchronizer or rising-edge detector, selected by EDGE_ONLY.
// EDGE_ONLY=1: input is already synchronous; output is a one-clk pulse on its
//              rising edge.
// EDGE_ONLY=0: input is asynchronous; output is the 2-FF synchronized level.
module usart_sync_edge #(
  parameter bit   EDGE_ONLY = 1'b0,
  parameter logic RST_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  if (EDGE_ONLY) begin : g_edge
    logic prev_q;

    // Remember the previous level so a low-to-high change can be seen
    always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= RST_VAL;
      else     prev_q <= d_i;
    end

    assign q_o = d_i & ~prev_q;
  end else begin : g_sync
    logic [1:0] sync_q;

    // Two metastability-hardening stages for the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= {2{RST_VAL}};
      else     sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
  end

endmodule

// File: rtl/usart_rx.sv
// UART receiver driven by a 16x (OVERSAMPLE) baud clock level. Recovers
// start / data (LSB first) / optional parity / stop frames, majority-votes
// three samples around mid-bit and hands words out on a valid/ready port.
module usart_rx
  import usart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkb,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_ovr
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] B_ALL  = BW'(DATA_BITS);

  logic tick;
  logic rx_s;

  usart_sync_edge #(.EDGE_ONLY(1'b1), .RST_VAL(1'b0)) u_tick (
    .clk (clk),
    .rst (rst),
    .d_i (clkb),
    .q_o (tick)
  );

  usart_sync_edge #(.EDGE_ONLY(1'b0), .RST_VAL(1'b1)) u_rxsync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  usart_state_e         state_q, state_d;
  logic                 armed_q, armed_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 perr_acc_q, perr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;

  // scnt_q is the index of the tick last processed within the current bit;
  // scnt_inc is the index this tick occupies. Wrapping to 0 marks a bit boundary.
  logic [SW-1:0] scnt_inc;
  logic          bit_end;
  logic          mid;
  logic          maj;

  assign bit_end  = (scnt_q == S_LAST);
  assign scnt_inc = bit_end ? '0 : scnt_q + 1'b1;
  assign mid      = (scnt_inc == S_MID);
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // Frame FSM and output handshake, all sampling gated by the baud tick
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    perr_acc_d = perr_acc_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = 1'b0;
    rx_ovr_d   = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (tick) begin
      if (state_q == IDLE) begin
        // A high line must be seen before a falling edge counts as a start
        if (!armed_q) begin
          if (rx_s) armed_d = 1'b1;
        end else if (!rx_s) begin
          state_d    = START;
          scnt_d     = '0;
          bcnt_d     = '0;
          perr_acc_d = 1'b0;
        end
      end else begin
        scnt_d = scnt_inc;
        if (scnt_inc == S_A) samp_d[0] = rx_s;
        if (scnt_inc == S_B) samp_d[1] = rx_s;

        case (state_q)
          START: begin
            if (mid && maj) begin
              state_d = IDLE;
              scnt_d  = '0;
            end else if (bit_end) begin
              state_d = DATA;
            end
          end
          DATA: begin
            if (mid) begin
              shift_d = {maj, shift_q[DATA_BITS-1:1]};
              bcnt_d  = bcnt_q + 1'b1;
            end
            if (bit_end && bcnt_q == B_ALL) begin
              bcnt_d  = '0;
              state_d = (PARITY != PAR_NONE) ? PAR : STOP;
            end
          end
          PAR: begin
            if (mid) perr_acc_d = maj ^ expected_parity(^shift_q, PARITY);
            if (bit_end) state_d = STOP;
          end
          STOP: begin
            // Act at mid-stop so back-to-back frames are not missed
            if (mid) begin
              state_d = IDLE;
              armed_d = 1'b0;
              scnt_d  = '0;
              if (!maj) begin
                rx_ferr_d = 1'b1;
              end else if (rx_valid_q && !rx_ready) begin
                rx_ovr_d = 1'b1;
              end else begin
                rx_data_d  = shift_q;
                rx_perr_d  = perr_acc_q;
                rx_valid_d = 1'b1;
              end
            end
          end
          default: begin
            state_d = IDLE;
            scnt_d  = '0;
          end
        endcase
      end
    end
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      perr_acc_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      perr_acc_q <= perr_acc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_perr  = rx_perr_q;
  assign rx_ferr  = rx_ferr_q;
  assign rx_ovr   = rx_ovr_q;

endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx: an 8N1 instance and an 8E1 instance share clk/clkb/rst
// and have separate serial lines. Received words, error pulses and the tick of
// each rising rx_valid are collected by a monitor and compared with values
// derived from the frames the bench sends.
module tb_usart_rx;

  localparam int BIT_CLK   = 256;  // 16 ticks x 16 clk per bit
  localparam int CLKB_HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkb = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1;
  logic       rdy = 1'b1, rdy_p = 1'b1;
  logic [7:0] d0, d1;
  logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

  int checks = 0;
  int failures = 0;

  usart_rx #(.DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .clkb(clkb), .rx(rx),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy),
    .rx_perr(pe0), .rx_ferr(fe0), .rx_ovr(ov0)
  );

  usart_rx #(.DATA_BITS(8), .PARITY(2), .OVERSAMPLE(16)) dut_p (
    .clk(clk), .rst(rst), .clkb(clkb), .rx(rx_p),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy_p),
    .rx_perr(pe1), .rx_ferr(fe1), .rx_ovr(ov1)
  );

  always #5 clk = ~clk;

  int clkb_cnt = 0;
  always @(posedge clk) begin
    if (clkb_cnt == CLKB_HALF - 1) begin
      clkb_cnt <= 0;
      clkb     <= ~clkb;
    end else begin
      clkb_cnt <= clkb_cnt + 1;
    end
  end

  int tick_cnt = 0;
  always @(posedge clkb) tick_cnt <= tick_cnt + 1;

  // Monitor: accepted words, error pulses, and when rx_valid rises
  logic [7:0] q0[$];
  logic       q0p[$];
  logic [7:0] q1[$];
  logic       q1p[$];
  int ferr0 = 0, ovr0 = 0, ferr1 = 0, ovr1 = 0;
  int vtick0 = 0;
  logic prev_v0 = 1'b0;

  always @(negedge clk) begin
    if (v0 && rdy) begin q0.push_back(d0); q0p.push_back(pe0); end
    if (v1 && rdy_p) begin q1.push_back(d1); q1p.push_back(pe1); end
    if (fe0) ferr0 <= ferr0 + 1;
    if (ov0) ovr0 <= ovr0 + 1;
    if (fe1) ferr1 <= ferr1 + 1;
    if (ov1) ovr1 <= ovr1 + 1;
    if (v0 && !prev_v0) vtick0 <= tick_cnt;
    prev_v0 <= v0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx = v;
    else            rx_p = v;
  endtask

  task automatic hold(input int nbits);
    repeat (nbits * BIT_CLK) @(posedge clk);
    #1;
  endtask

  // One serial frame, started just after a clkb rise, followed by a line level
  task automatic send_frame(input int which, input logic [7:0] data, input bit use_par,
                            input logic pbit, input logic stop, input logic idle_lvl,
                            input int idle_bits, output int start_tick);
    @(posedge clkb);
    #1;
    start_tick = tick_cnt;
    drive(which, 1'b0);
    hold(1);
    for (int i = 0; i < 8; i++) begin
      drive(which, data[i]);
      hold(1);
    end
    if (use_par) begin
      drive(which, pbit);
      hold(1);
    end
    drive(which, stop);
    hold(1);
    drive(which, idle_lvl);
    hold(idle_bits);
  endtask

  // Exactly one word expected on the given instance since the last call
  task automatic expect_word(input int which, input string tag, input logic [7:0] exp_d,
                             input logic exp_pe);
    if (which == 0) begin
      check({tag, "_count"}, q0.size(), 1);
      if (q0.size() > 0) begin
        check({tag, "_data"}, q0[0], exp_d);
        check({tag, "_perr"}, q0p[0], exp_pe);
      end
      q0.delete();
      q0p.delete();
    end else begin
      check({tag, "_count"}, q1.size(), 1);
      if (q1.size() > 0) begin
        check({tag, "_data"}, q1[0], exp_d);
        check({tag, "_perr"}, q1p[0], exp_pe);
      end
      q1.delete();
      q1p.delete();
    end
  endtask

  // Reference rule for even parity: error when the sent bit differs from the XOR of the data
  function automatic logic even_perr(input logic [7:0] d, input logic pbit);
    return pbit != logic'($countones(d) % 2);
  endfunction

  int st;
  int lat;
  int fe_before, ov_before;
  logic [7:0] rd;
  logic       rp;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", d0, 0);
    check("rst_valid", v0, 0);
    check("rst_perr", pe0, 0);
    check("rst_ferr", fe0, 0);
    check("rst_ovr", ov0, 0);
    check("rst_valid_p", v1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    hold(2);

    // 8N1 frame 0xA5 with latency
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1'b1, 1, st);
    expect_word(0, "a5", 8'hA5, 1'b0);
    lat = vtick0 - st;
    $display("frame a5: latency %0d ticks", lat);
    check("a5_latency_ok", (lat >= 151 && lat <= 153), 1);
    check("a5_ferr", ferr0, 0);
    check("a5_ovr", ovr0, 0);

    // Two-tick glitch then 0x3C
    @(posedge clkb);
    #1 rx = 1'b0;
    repeat (32) @(posedge clk);
    #1 rx = 1'b1;
    hold(2);
    check("glitch_words", q0.size(), 0);
    check("glitch_ferr", ferr0, 0);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 1'b1, 1, st);
    expect_word(0, "3c", 8'h3C, 1'b0);

    // Framing error with the line held low afterwards, then 0x0F
    send_frame(0, 8'h55, 0, 1'b0, 1'b0, 1'b0, 3, st);
    check("ferr_count", ferr0, 1);
    check("ferr_words", q0.size(), 0);
    check("ferr_valid", v0, 0);
    rx = 1'b1;
    hold(1);
    send_frame(0, 8'h0F, 0, 1'b0, 1'b1, 1'b1, 1, st);
    expect_word(0, "0f", 8'h0F, 1'b0);
    check("ferr_count_after", ferr0, 1);

    // Even parity instance
    send_frame(1, 8'h07, 1, 1'b0, 1'b1, 1'b1, 1, st);
    expect_word(1, "par07_bad", 8'h07, 1'b1);
    send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1'b1, 1, st);
    expect_word(1, "par07_ok", 8'h07, 1'b0);

    // Overrun with consumer stalled
    rdy = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1'b1, 1, st);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1, 1'b1, 1, st);
    check("ovr_valid_held", v0, 1);
    check("ovr_data_kept", d0, 8'h11);
    check("ovr_count", ovr0, 1);
    check("ovr_words", q0.size(), 0);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_clear", v0, 0);
    expect_word(0, "ovr_accept", 8'h11, 1'b0);

    // Reset during data bit 4 of 0xFF, then 0x81
    fe_before = ferr0;
    ov_before = ovr0;
    fork
      send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 1'b1, 1, st);
      begin
        repeat (5 * BIT_CLK + 128) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_data", d0, 0);
        check("midrst_valid", v0, 0);
        check("midrst_perr", pe0, 0);
        check("midrst_ferr", fe0, 0);
        check("midrst_ovr", ov0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    check("abort_words", q0.size(), 0);
    check("abort_ferr", ferr0, fe_before);
    check("abort_ovr", ovr0, ov_before);
    send_frame(0, 8'h81, 0, 1'b0, 1'b1, 1'b1, 1, st);
    expect_word(0, "81", 8'h81, 1'b0);

    // Randomized 8N1 frames
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      $display("random 8N1 frame %0d: data %02h", i, rd);
      send_frame(0, rd, 0, 1'b0, 1'b1, 1'b1, 1, st);
      expect_word(0, "rand", rd, 1'b0);
    end

    // Randomized even-parity frames with a random parity bit
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      $display("random 8E1 frame %0d: data %02h parity bit %0d", i, rd, rp);
      send_frame(1, rd, 1, rp, 1'b1, 1'b1, 1, st);
      expect_word(1, "rand_par", rd, even_perr(rd, rp));
    end
    check("final_ferr_p", ferr1, 0);
    check("final_ovr_p", ovr1, 0);
    check("final_ovr", ovr0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usart_rx.md
# usart_rx

UART receive stage fed by the 16x oversampling baud clock from the baud generator. It recovers asynchronous serial frames: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit. It presents each received word on a valid/ready interface to the downstream frequency-measurement command logic. Framing, parity and overrun errors are reported.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- OVERSAMPLE, 16, baud-clock periods per bit; must match the generator
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- clkb  in  1  16x baud clock from the baud generator: a level signal, synchronous to clk
- rx  in  1  serial line, asynchronous, idle high
- rx_data  out  DATA_BITS  received word, valid while rx_valid=1
- rx_valid  out  1  word available; held until accepted
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready at a clk edge
- rx_perr  out  1  parity error for the word currently on rx_data; qualified by rx_valid
- rx_ferr  out  1  one-cycle pulse: stop bit sampled low
- rx_ovr  out  1  one-cycle pulse: a word completed while the previous one was unaccepted

## Operation
- tick = rising edge of clkb: clkb is registered and compared, giving a one-clk pulse. All sampling is gated by tick.
- rx passes through a 2-FF synchronizer to give rx_s. No other logic reads raw rx.
- States: IDLE, START, DATA, PAR, STOP. scnt (0..OVERSAMPLE-1) counts ticks within a bit. bcnt counts data bits.
- IDLE: the state is armed once rx_s=1 is seen on a tick. When armed and rx_s=0 on a tick, go to START and set scnt=0.
- Bit value is the majority of rx_s at scnt = OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2. It is evaluated at scnt = OVERSAMPLE/2.
- START: if the majority is 1, the start was a glitch; return to IDLE. Otherwise continue to scnt = OVERSAMPLE-1, then go to DATA.
- DATA: shift each bit into the MSB of the shift register, LSB first. After DATA_BITS bits, go to PAR if PARITY≠0, else go to STOP.
- PAR: compare the sampled bit with the computed parity. The result is latched with the word.
- STOP: act at the mid-bit evaluation; do not wait for the end of the stop bit.
  - If the stop bit is 1: load rx_data and rx_perr and set rx_valid.
  - If rx_valid is already set and not accepted that cycle: keep the old word and pulse rx_ovr instead.
  - If the stop bit is 0: pulse rx_ferr, discard the word and skip the other actions.
  - In all cases, go to IDLE disarmed. This forces the idle-high requirement and keeps a break condition from re-triggering.
- Handshake: rx_valid clears on the clk after acceptance. Acceptance and a new word completing in the same cycle is not an overrun: the new word loads and rx_valid stays 1.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_perr=0, rx_ferr=0, rx_ovr=0, state=IDLE disarmed, counters=0, clkb register=0, synchronizer=1.
- Reset asserted mid-frame aborts the frame immediately. Nothing is emitted for it.
- rx to rx_s latency: 2 clk.
- tick latency: 1 clk after the clkb rising edge.
- rx_valid, rx_ferr and rx_ovr assert on the clk edge after the tick carrying the stop-bit mid-sample. This is about (DATA_BITS + P + 1.5) × OVERSAMPLE ticks after the start edge, where P = 1 with parity, else 0.
- Ticks must be at least 3 clk apart. rx_ready may be held high continuously.
- Counter widths: scnt is $clog2(OVERSAMPLE). bcnt is $clog2(DATA_BITS+1). Neither wraps within a frame: each resets on every bit or state transition.

## Structure
- Shared package usart_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP)
  - the PARITY encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
- One sub-module, usart_sync_edge: 2-FF synchronizer plus rising-edge detector. It is instantiated for clkb (edge only) and for rx (synchronizer only), selected by parameter.
- Expected size: about 200 lines.

## Test plan
- 8N1, bench clkb at 16 clk period, frame 0xA5, rx_ready=1 → one rx_valid pulse, rx_data=0xA5, rx_perr=0, no rx_ferr or rx_ovr. Valid appears 152 ticks ±1 after the start edge.
- 2-tick low glitch on idle rx → stays in IDLE, no outputs, and the next real frame 0x3C is received correctly.
- Frame 0x55 with the stop bit forced low → one rx_ferr pulse, rx_valid stays 0. A following 0x0F frame is received only after rx has returned high.
- PARITY=2, frame 0x07 sent with parity bit 0 → rx_valid=1, rx_data=0x07, rx_perr=1. The same frame with parity bit 1 → rx_perr=0.
- rx_ready=0, frames 0x11 then 0x22 → rx_data stays 0x11 and one rx_ovr pulse occurs. Raising rx_ready then clears rx_valid next clk.
- rst pulsed during data bit 4 of 0xFF, then frame 0x81 → nothing emitted for the aborted frame, all outputs 0 during reset, then rx_data=0x81.
